// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Pipeline-stage register with a valid/ready handshake and a two-entry skid
// buffer. It carries one stage's bundled word between processor pipeline
// stages, and it supports stall (backpressure), flush (squash) and a
// saturating stall-cycle counter.
//
// in_ready is decoded only from registered state. There is therefore no
// combinational path from out_ready to in_ready. When the downstream stalls
// in the same cycle that a word is accepted, the skid entry absorbs that word.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     upstream word valid
//   in_data      upstream word (WIDTH bits)
//   in_ready     stage can accept a word this cycle
//   out_valid    downstream word valid
//   out_data     downstream word (WIDTH bits)
//   out_ready    downstream accepts the word this cycle
//   flush        synchronous squash of all held words
//   clear_stats  synchronous clear of stall_count
//   occupancy    number of words held (0, 1 or 2)
//   stall_count  saturating count of cycles where out_valid & !out_ready
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int                 WIDTH       = 32,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   parameter int                 CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   input  logic                  out_ready,
   input  logic                  flush,
   input  logic                  clear_stats,
   output logic [1:0]            occupancy,
   output logic [CNT_WIDTH-1:0]  stall_count
);

   // The state encoding equals the number of held words, so occupancy is
   // simply the state register.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] STALL_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] STALL_ONE = CNT_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       main_q,  main_d;
   logic [WIDTH-1:0]       skid_q,  skid_d;
   logic [CNT_WIDTH-1:0]   stall_q, stall_d;

   logic                   acc;
   logic                   drn;

   assign out_valid   = (state_q != ST_EMPTY);
   assign in_ready    = (state_q != ST_FULL);
   assign out_data    = main_q;
   assign occupancy   = state_q;
   assign stall_count = stall_q;

   assign acc = in_valid & in_ready;
   assign drn = out_valid & out_ready;

   // Next-state and data-path logic. A flush overrides every transition.
   // Only the state returns to EMPTY on a flush. main_q keeps its value,
   // so out_data does not change. A word that drains in the flush cycle
   // counts as delivered.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  main_d  = in_data;
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (acc && drn) begin
                  main_d = in_data;
               end else if (acc) begin
                  // The downstream stalled while a word arrived, so the skid
                  // entry parks the new word behind the one in main.
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end else if (drn) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drn) begin
                  main_d  = skid_q;
                  state_d = ST_BUSY;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Stall statistics. clear_stats wins over the increment. The counter
   // saturates at its maximum value. Cycles with a flush are not counted.
   always_comb begin
      stall_d = stall_q;
      if (clear_stats) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && !flush && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + STALL_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Self-checking bench for pipe_skid_reg. The bench uses two instances that
// share every input:
//   dut_a  CNT_WIDTH=16. The full check of data, handshake and occupancy
//          is applied to this instance.
//   dut_b  CNT_WIDTH=2. This instance is used to observe counter saturation.
//
// The reference model has two parts. The first is a queue of the words the
// stage currently holds. The second is a pair of saturating counters.
// Both parts derive from the handshake rules alone.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

   localparam logic [31:0] RST_VAL = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic        clear_stats = 1'b0;

   logic        in_ready_a, out_valid_a;
   logic [31:0] out_data_a;
   logic [1:0]  occupancy_a;
   logic [15:0] stall_count_a;

   logic        in_ready_b, out_valid_b;
   logic [31:0] out_data_b;
   logic [1:0]  occupancy_b;
   logic [1:0]  stall_count_b;

   int checks = 0;
   int fails  = 0;

   // Scoreboard: the words the stage should be holding, oldest first.
   logic [31:0] exp_q[$];
   bit          exp_acc = 1'b0;
   logic [31:0] last_main = RST_VAL;
   int unsigned cnt_a = 0;
   int unsigned cnt_b = 0;

   pipe_skid_reg #(.WIDTH(32), .RESET_VALUE(RST_VAL), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
      .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
      .flush(flush), .clear_stats(clear_stats),
      .occupancy(occupancy_a), .stall_count(stall_count_a)
   );

   pipe_skid_reg #(.WIDTH(32), .RESET_VALUE(RST_VAL), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
      .flush(flush), .clear_stats(clear_stats),
      .occupancy(occupancy_b), .stall_count(stall_count_b)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge. If the word will
   // be accepted, push it to the scoreboard now. The stage can take a word
   // when it holds fewer than two. A word that arrives during a flush is lost.
   task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic r,
                                 input logic f, input logic c);
      @(posedge clk);
      #2;
      in_valid    = v;
      in_data     = d;
      out_ready   = r;
      flush       = f;
      clear_stats = c;
      exp_acc     = 1'b0;
      if (!reset && v && !f && (exp_q.size() < 2)) begin
         exp_q.push_back(d);
         exp_acc = 1'b1;
      end
   endtask

   // Monitor: at the falling edge, compare the DUT's visible state with the
   // model. Then apply this cycle's transfer events to the model.
   always @(negedge clk) begin
      int  held;
      bit  drn;
      if (reset) begin
         exp_q.delete();
         exp_acc   = 1'b0;
         last_main = RST_VAL;
         cnt_a     = 0;
         cnt_b     = 0;
      end else begin
         held = exp_q.size() - int'(exp_acc);
         check_output("out_valid", 32'(out_valid_a), 32'(held > 0));
         check_output("in_ready", 32'(in_ready_a), 32'(held < 2));
         check_output("occupancy", 32'(occupancy_a), 32'(held));
         if (held > 0) begin
            check_output("out_data", out_data_a, exp_q[0]);
            last_main = exp_q[0];
         end else begin
            check_output("out_data_idle", out_data_a, last_main);
         end
         check_output("stall_count_a", 32'(stall_count_a), cnt_a);
         check_output("stall_count_b", 32'(stall_count_b), cnt_b);

         drn = (held > 0) && out_ready;
         if (drn) void'(exp_q.pop_front());
         if (flush) exp_q.delete();

         if (clear_stats) begin
            cnt_a = 0;
            cnt_b = 0;
         end else if ((held > 0) && !out_ready && !flush) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 3) cnt_b++;
         end
         exp_acc = 1'b0;
      end
   end

   initial begin
      $display("[TB] starting pipe_skid_reg bench");

      // Reset state
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_output("rst_out_valid", 32'(out_valid_a), 32'd0);
      check_output("rst_out_data", out_data_a, RST_VAL);
      check_output("rst_in_ready", 32'(in_ready_a), 32'd1);
      check_output("rst_occupancy", 32'(occupancy_a), 32'd0);
      check_output("rst_stall", 32'(stall_count_a), 32'd0);

      // Single word, one-cycle latency
      apply_stimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("first_valid", 32'(out_valid_a), 32'd1);
      check_output("first_data", out_data_a, 32'h11);
      check_output("first_occ", 32'(occupancy_a), 32'd1);
      check_output("first_stall", 32'(stall_count_a), 32'd0);

      // Back-to-back stream at full throughput
      for (int i = 1; i <= 8; i++) begin
         apply_stimulus(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
         #1;
         check_output("stream_in_ready", 32'(in_ready_a), 32'd1);
      end
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

      // Fill then stall
      apply_stimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      repeat (3) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("full_stall", 32'(stall_count_a), 32'd4);
      check_output("full_occ", 32'(occupancy_a), 32'd2);
      check_output("full_in_ready", 32'(in_ready_a), 32'd0);
      check_output("full_data", out_data_a, 32'hA);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("drain_second", out_data_a, 32'hB);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Flush while FULL, with a word offered in the flush cycle
      apply_stimulus(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'hE, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("flush_valid", 32'(out_valid_a), 32'd0);
      check_output("flush_occ", 32'(occupancy_a), 32'd0);
      check_output("flush_in_ready", 32'(in_ready_a), 32'd1);
      check_output("flush_data_kept", out_data_a, 32'hD);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Saturation of the 2-bit counter, then clear
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
      repeat (6) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      check_output("sat_b", 32'(stall_count_b), 32'd3);
      check_output("sat_a", 32'(stall_count_a), 32'd6);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("clear_b", 32'(stall_count_b), 32'd0);
      check_output("clear_a", 32'(stall_count_a), 32'd0);

      // Asynchronous reset mid-cycle while FULL
      apply_stimulus(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'h32, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      check_output("pre_reset_occ", 32'(occupancy_a), 32'd2);
      reset = 1'b1;
      #1;
      check_output("async_out_valid", 32'(out_valid_a), 32'd0);
      check_output("async_out_data", out_data_a, RST_VAL);
      check_output("async_in_ready", 32'(in_ready_a), 32'd1);
      check_output("async_occ", 32'(occupancy_a), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         apply_stimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                        $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
      end
      // Long stall bursts to stress the skid path
      for (int i = 0; i < 200; i++) begin
         apply_stimulus(1'b1, $urandom, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      end
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
